snes_poller: RTL
================

// Module: snes_poller
// PURPOSE
//  Downstream consumer of the SNES controller interface. Every POLL_CYCLES clocks it
//  - starts a controller scan,
//  - waits for the scan to finish,
//  - reads pad 0 and pad 1 back.
//  It holds the current button state plus sticky "newly pressed" bits for the CPU
//  data bus, so firmware never drives the SNES handshake itself.
// PARAMETERS
//  POLL_CYCLES  208333  clocks between scan starts (60 Hz @ 12.5 MHz); must be > SCAN_WAIT+8
//  SCAN_WAIT    64      clocks from scan trigger until pad data is stable (scan takes ~55)
//  CNT_W        18      poll counter width; must satisfy 2**CNT_W > POLL_CYCLES
// PORTS
//  clk               input   1   system clock, 12.5 MHz
//  rst               input   1   reset; asynchronous, active-low (0 = reset)
//  snes_read_enable  output  1   read strobe to the SNES interface
//  snes_address      output  2   0 = read pad0, 1 = read pad1, 2 = start scan
//  snes_read_data    input   12  registered pad data; valid 1 clk after strobe
//  cpu_rd            input   1   CPU read strobe
//  cpu_sel           input   2   0 = pad0 state, 1 = pad1 state, 2 = pad0 press, 3 = pad1 press
//  cpu_data          output  12  registered CPU read data
//  frame_valid       output  1   1-clk pulse when a new pad0/pad1 pair is committed
//  busy              output  1   high whenever the FSM is not IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all outputs are 0; state0/1 and press0/1 are 0; FSM goes to IDLE.
//   - Poll counter loads POLL_CYCLES-1.
//   - Reset mid-scan abandons the scan. No partial commit.
//  Poll counter:
//   - free-running down-counter.
//   - At 0 it reloads POLL_CYCLES-1 and raises a 1-clk tick.
//  FSM (one state per clk unless stated):
//   - IDLE:  on tick -> TRIG.
//   - TRIG:  snes_read_enable=1, snes_address=2 -> WAIT. Wait counter loads SCAN_WAIT-1.
//   - WAIT:  count down; at 0 -> RD0.
//   - RD0:   read_enable=1, addr=0 -> RD1.
//   - RD1:   read_enable=1, addr=1; capture snes_read_data into tmp0 -> CAP1.
//   - CAP1:  capture snes_read_data into tmp1 -> COMMIT.
//   - COMMIT:
//     - press0 <= press0 | (tmp0 & ~state0); press1 likewise.
//     - state0 <= tmp0; state1 <= tmp1.
//     - frame_valid=1 -> IDLE.
//  Outside TRIG/RD0/RD1: snes_read_enable=0 and snes_address=0.
//  Scan total: SCAN_WAIT+5 clocks from TRIG to COMMIT inclusive.
//  A tick arriving while busy is impossible by the POLL_CYCLES constraint.
//  CPU reads:
//   - On cpu_rd, cpu_data <= selected register the next clk. Otherwise cpu_data holds.
//   - Reading sel 2 or 3 clears that press register.
//   - Read and COMMIT in the same clk:
//     - cpu_data returns the pre-commit value;
//     - the register becomes only the new edges (tmp & ~state), i.e. clear-then-set.
//  Widths: all button words are 12 bits, with no arithmetic on them. Counters wrap only via reload.
// CONFIGURATION
//  SNES_DEBOUNCE_EN defined:
//   - COMMIT updates state0/1 only with bits equal in this scan and the previous scan.
//   - Other bits keep their old state value.
//   - press bits derive from the debounced state.
//   - A last-scan shadow register pair is added and reset to 0.
//  SNES_DEBOUNCE_EN undefined: a single sample is committed directly, as above.
// STRUCTURE
//  Package snes_pkg holds:
//   - FSM state encodings: IDLE, TRIG, WAIT, RD0, RD1, CAP1, COMMIT;
//   - SNES address codes SNES_ADDR_PAD0=0, PAD1=1, SCAN=2;
//   - cpu_sel codes.
//  Sub-module snes_poll_timer: poll down-counter and tick (params POLL_CYCLES, CNT_W).
//  The FSM, the capture registers and the CPU mux stay in snes_poller.
// TESTING (POLL_CYCLES=100, SCAN_WAIT=20; model returns read_data 1 clk after strobe)
//  1 Reset scan timing:
//    - release rst -> first TRIG strobe (addr 2) at clk 100;
//    - RD0 (addr 0) at clk 121 and RD1 (addr 1) at clk 122;
//    - frame_valid at clk 124. Repeats every 100 clks.
//  2 Button state:
//    - model pad0=12'h801, pad1=12'h040 -> after frame_valid, cpu_sel=0 reads 12'h801 and sel=1 reads 12'h040.
//  3 Press edges:
//    - pad0 goes 12'h001 then 12'h003 -> sel=2 reads 12'h003;
//    - a second sel=2 read returns 12'h000 (cleared).
//  4 Read during commit:
//    - cpu_rd sel=2 in the COMMIT clk with new press 12'h010 -> returns old value;
//    - the next read returns 12'h010.
//  5 Reset mid-scan:
//    - drive rst=0 during WAIT -> outputs 0 immediately, no frame_valid;
//    - the next scan starts 100 clks after release.
//  6 SNES_DEBOUNCE_EN:
//    - pad0 samples 12'h001, 12'h000, 12'h000 -> state0 stays 12'h000 after the first commit (0 -> 0).
//    - Samples 12'h001, 12'h001 -> state0=12'h001 only after the second commit.

Source files
------------

// File: rtl/snes_pkg.sv
// snes_pkg
//   Shared definitions for the SNES pad poller: FSM state encoding, the
//   address codes understood by the SNES controller interface, the CPU
//   register select codes and two small helpers for button words.
//   No ports (package).
package snes_pkg;

  localparam int BTN_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    RD0,
    RD1,
    CAP1,
    COMMIT
  } poll_state_t;

  localparam logic [1:0] SNES_ADDR_PAD0 = 2'd0;
  localparam logic [1:0] SNES_ADDR_PAD1 = 2'd1;
  localparam logic [1:0] SNES_ADDR_SCAN = 2'd2;

  localparam logic [1:0] CPU_SEL_STATE0 = 2'd0;
  localparam logic [1:0] CPU_SEL_STATE1 = 2'd1;
  localparam logic [1:0] CPU_SEL_PRESS0 = 2'd2;
  localparam logic [1:0] CPU_SEL_PRESS1 = 2'd3;

  // Buttons that are down now but were up in the previously committed state.
  function automatic logic [BTN_W-1:0] rising_edges(input logic [BTN_W-1:0] now_state,
                                                    input logic [BTN_W-1:0] old_state);
    return now_state & ~old_state;
  endfunction

  // A bit only moves to the new sample when two consecutive scans agree on it;
  // disagreeing bits keep whatever was last committed.
  function automatic logic [BTN_W-1:0] debounce_merge(input logic [BTN_W-1:0] old_state,
                                                      input logic [BTN_W-1:0] sample,
                                                      input logic [BTN_W-1:0] last_sample);
    logic [BTN_W-1:0] stable;
    stable = ~(sample ^ last_sample);
    return (sample & stable) | (old_state & ~stable);
  endfunction

endpackage

// File: rtl/snes_poll_timer.sv
// snes_poll_timer
//   Free-running poll down-counter. Loads POLL_CYCLES-1 in reset, counts down,
//   and when it sits at zero it reloads and raises tick for that one clock.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   tick  out  one-clock pulse every POLL_CYCLES clocks
module snes_poll_timer #(
  parameter int POLL_CYCLES = 208333,
  parameter int CNT_W       = 18
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Tick is decoded from the counter register, so it is glitch-free and is
  // seen by the FSM on the same edge that reloads the counter.
  assign tick = (count == '0);

  // Down-counter; wraps only by reloading, never by underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/snes_poller.sv
// snes_poller
//   Periodically scans both SNES pads through the controller interface and
//   keeps the current button state plus sticky "newly pressed" bits for the
//   CPU. Firmware only reads registers; it never drives the SNES handshake.
//   Optional build macro: SNES_DEBOUNCE_EN (commit only bits that agree in two
//   consecutive scans; adds a last-scan shadow register pair).
// Ports
//   clk               in   system clock
//   rst               in   asynchronous active-low reset
//   snes_read_enable  out  read strobe to the SNES interface
//   snes_address      out  0 = pad0, 1 = pad1, 2 = start scan
//   snes_read_data    in   pad data, valid one clock after the strobe
//   cpu_rd            in   CPU read strobe
//   cpu_sel           in   0/1 = pad0/pad1 state, 2/3 = pad0/pad1 press
//   cpu_data          out  registered CPU read data
//   frame_valid       out  one-clock pulse while a new pad pair is committed
//   busy              out  high whenever the FSM is not idle
module snes_poller
  import snes_pkg::*;
#(
  parameter int POLL_CYCLES = 208333,
  parameter int SCAN_WAIT   = 64,
  parameter int CNT_W       = 18
) (
  input  logic             clk,
  input  logic             rst,
  output logic             snes_read_enable,
  output logic [1:0]       snes_address,
  input  logic [BTN_W-1:0] snes_read_data,
  input  logic             cpu_rd,
  input  logic [1:0]       cpu_sel,
  output logic [BTN_W-1:0] cpu_data,
  output logic             frame_valid,
  output logic             busy
);

  localparam int WAIT_W = (SCAN_WAIT > 1) ? $clog2(SCAN_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(SCAN_WAIT - 1);

  poll_state_t      fsm;
  logic             poll_tick;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BTN_W-1:0] tmp0, tmp1;
  logic [BTN_W-1:0] state0, state1;
  logic [BTN_W-1:0] press0, press1;
  logic [BTN_W-1:0] next0, next1;
  logic             clr0, clr1;

  snes_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .tick(poll_tick)
  );

  // A CPU read of a press register clears it on the same edge that returns it.
  assign clr0 = cpu_rd && (cpu_sel == CPU_SEL_PRESS0);
  assign clr1 = cpu_rd && (cpu_sel == CPU_SEL_PRESS1);

  assign busy = (fsm != IDLE);

`ifdef SNES_DEBOUNCE_EN
  logic [BTN_W-1:0] last0, last1;

  assign next0 = debounce_merge(state0, tmp0, last0);
  assign next1 = debounce_merge(state1, tmp1, last1);

  // Shadow of the previous raw scan, compared against the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last0 <= '0;
      last1 <= '0;
    end else if (fsm == COMMIT) begin
      last0 <= tmp0;
      last1 <= tmp1;
    end
  end
`else
  assign next0 = tmp0;
  assign next1 = tmp1;
`endif

  // Scan sequencer. SNES outputs are registered: each transition sets the
  // strobe/address that belong to the state being entered, and everything
  // defaults back to zero. The commit happens on the edge leaving COMMIT, so
  // a CPU read in that clock still sees the pre-commit value and a press
  // register read then is cleared first and then set with the new edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm              <= IDLE;
      snes_read_enable <= 1'b0;
      snes_address     <= SNES_ADDR_PAD0;
      frame_valid      <= 1'b0;
      wait_cnt         <= '0;
      tmp0             <= '0;
      tmp1             <= '0;
      state0           <= '0;
      state1           <= '0;
      press0           <= '0;
      press1           <= '0;
    end else begin
      snes_read_enable <= 1'b0;
      snes_address     <= SNES_ADDR_PAD0;
      frame_valid      <= 1'b0;
      if (clr0) press0 <= '0;
      if (clr1) press1 <= '0;
      case (fsm)
        IDLE: begin
          if (poll_tick) begin
            fsm              <= TRIG;
            snes_read_enable <= 1'b1;
            snes_address     <= SNES_ADDR_SCAN;
          end
        end
        TRIG: begin
          fsm      <= WAIT;
          wait_cnt <= WAIT_RELOAD;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            fsm              <= RD0;
            snes_read_enable <= 1'b1;
            snes_address     <= SNES_ADDR_PAD0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RD0: begin
          fsm              <= RD1;
          snes_read_enable <= 1'b1;
          snes_address     <= SNES_ADDR_PAD1;
        end
        RD1: begin
          tmp0 <= snes_read_data;
          fsm  <= CAP1;
        end
        CAP1: begin
          tmp1        <= snes_read_data;
          fsm         <= COMMIT;
          frame_valid <= 1'b1;
        end
        COMMIT: begin
          state0 <= next0;
          state1 <= next1;
          press0 <= (clr0 ? '0 : press0) | rising_edges(next0, state0);
          press1 <= (clr1 ? '0 : press1) | rising_edges(next1, state1);
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // CPU register read port; holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_data <= '0;
    end else if (cpu_rd) begin
      case (cpu_sel)
        CPU_SEL_STATE0: cpu_data <= state0;
        CPU_SEL_STATE1: cpu_data <= state1;
        CPU_SEL_PRESS0: cpu_data <= press0;
        default:        cpu_data <= press1;
      endcase
    end
  end

endmodule
